// File: rtl/car_queue_fr_if.sv
// Handshake-free bus between the farm-road departure logic (master) and the car queue (slave).
// Inputs are sampled on the traffic clock; all outputs except car_arrived are registered.
interface car_queue_fr_if;
    logic [4:0] arrival_Level_SWs;
    logic       add_Car;
    logic       car_in_queue;
    logic       queue_full;
    logic [3:0] queue_count;
    logic       car_arrived;
    logic       farm_sensor;
    logic [7:0] head_wait;

    modport master (
        output arrival_Level_SWs, add_Car,
        input  car_in_queue, queue_full, queue_count, car_arrived, farm_sensor, head_wait
    );

    modport slave (
        input  arrival_Level_SWs, add_Car,
        output car_in_queue, queue_full, queue_count, car_arrived, farm_sensor, head_wait
    );
endinterface

// File: rtl/car_queue_fr.sv
// Farm-road car queue: LFSR-driven arrivals, departure pulses, occupancy, sensor request and head wait.
// Count/flags update one edge after the event; farm_sensor rises SENSOR_DELAY edges after the first car.
module car_queue_fr #(
    parameter logic [4:0] INITALIZE_RAND = 5'd1,
    parameter int         MAX_CARS       = 15,
    parameter int         SENSOR_DELAY   = 3
) (
    input  logic          traffic_clk,
    input  logic          reset,
    car_queue_fr_if.slave bus
);
    // All-ones is the XNOR lock-up state and would freeze the generator.
    localparam logic [4:0] SEED    = (INITALIZE_RAND == 5'b11111) ? 5'b00000 : INITALIZE_RAND;
    localparam logic [3:0] MAX_CNT = 4'(MAX_CARS);
    localparam logic [7:0] DELAY   = 8'(SENSOR_DELAY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQUEST} state_t;

    logic [4:0] r_rand;
    logic [3:0] r_queue_count;
    logic [7:0] r_head_wait;
    logic [7:0] r_wait_cnt;
    logic       r_farm_sensor;
    state_t     r_state;

    logic w_full;
    logic w_nonempty;
    logic w_arrive;
    logic w_depart;

    assign w_full     = (r_queue_count == MAX_CNT);
    assign w_nonempty = (r_queue_count != 4'd0);
    assign w_arrive   = !reset && (bus.arrival_Level_SWs > r_rand) && !w_full;
    assign w_depart   = bus.add_Car && w_nonempty;

    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            r_rand        <= SEED;
            r_queue_count <= 4'd0;
            r_head_wait   <= 8'd0;
        end else begin
            r_rand <= {~(r_rand[2] ^ r_rand[0]), r_rand[4:1]};
            case ({w_arrive, w_depart})
                2'b10:   r_queue_count <= r_queue_count + 4'd1;
                2'b01:   r_queue_count <= r_queue_count - 4'd1;
                default: r_queue_count <= r_queue_count;
            endcase
            // A departure hands the head position to the next car, whose wait starts over.
            if (w_depart || !w_nonempty)
                r_head_wait <= 8'd0;
            else if (r_head_wait != 8'hFF)
                r_head_wait <= r_head_wait + 8'd1;
        end
    end

    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 8'd0;
            r_farm_sensor <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_nonempty) begin
                        r_wait_cnt <= 8'd1;
                        if (DELAY == 8'd1) begin
                            r_state       <= S_REQUEST;
                            r_farm_sensor <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_nonempty) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        // Compare the incremented count so the sensor rises SENSOR_DELAY edges after arrival.
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                        if (r_wait_cnt + 8'd1 == DELAY) begin
                            r_state       <= S_REQUEST;
                            r_farm_sensor <= 1'b1;
                        end
                    end
                end
                S_REQUEST: begin
                    if (!w_nonempty) begin
                        r_state       <= S_IDLE;
                        r_wait_cnt    <= 8'd0;
                        r_farm_sensor <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_wait_cnt    <= 8'd0;
                    r_farm_sensor <= 1'b0;
                end
            endcase
        end
    end

    assign bus.car_in_queue = w_nonempty;
    assign bus.queue_full   = w_full;
    assign bus.queue_count  = r_queue_count;
    assign bus.car_arrived  = w_arrive;
    assign bus.farm_sensor  = r_farm_sensor;
    assign bus.head_wait    = r_head_wait;
endmodule

// File: tb/tb_car_queue_fr.sv
// Directed bench for car_queue_fr: stimulus pushes hand-derived expectations, a negedge monitor checks them.
module tb_car_queue_fr;
    logic traffic_clk = 1'b0;
    logic reset       = 1'b1;

    car_queue_fr_if bus_if();

    car_queue_fr #(.INITALIZE_RAND(5'd1), .MAX_CARS(15), .SENSOR_DELAY(3)) dut (
        .traffic_clk (traffic_clk),
        .reset       (reset),
        .bus         (bus_if)
    );

    always #5 traffic_clk = ~traffic_clk;

    typedef struct packed {
        logic [7:0] id;
        logic [3:0] cnt;
        logic       ciq;
        logic       full;
        logic       arr;
        logic       sen;
        logic [7:0] hw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] test_id = 8'd0;

    // Mixed arrive/depart sequence starting from an empty, idle queue.
    logic [4:0] t_lvl [19] = '{31,31,31,31,31,31, 0, 0,31,31, 0, 0, 0, 0,31,31, 0, 0, 0};
    logic       t_add [19] = '{ 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [3:0] t_cnt [19] = '{ 0, 1, 2, 3, 4, 4, 4, 3, 2, 2, 3, 3, 2, 1, 0, 1, 1, 1, 1};
    logic       t_arr [19] = '{ 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic       t_sen [19] = '{ 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
    logic [7:0] t_hw  [19] = '{ 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, 2};

    // Drive one cycle of inputs just after the edge; expectation is what the monitor sees mid-cycle.
    task automatic step(input logic rst_v, input logic [4:0] lvl, input logic add,
                        input logic [3:0] cnt, input logic arr, input logic sen, input logic [7:0] hw);
        exp_t e;
        @(posedge traffic_clk);
        #2;
        reset                    = rst_v;
        bus_if.arrival_Level_SWs = lvl;
        bus_if.add_Car           = add;
        e.id   = test_id;
        e.cnt  = cnt;
        e.ciq  = (cnt != 4'd0);
        e.full = (cnt == 4'd15);
        e.arr  = arr;
        e.sen  = sen;
        e.hw   = hw;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge traffic_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus_if.queue_count !== e.cnt || bus_if.car_in_queue !== e.ciq ||
                    bus_if.queue_full !== e.full || bus_if.car_arrived !== e.arr ||
                    bus_if.farm_sensor !== e.sen || bus_if.head_wait !== e.hw) begin
                    errors++;
                    $display("FAIL t%0d @%0t: got cnt=%0d ciq=%b full=%b arr=%b sen=%b hw=%0d, want cnt=%0d ciq=%b full=%b arr=%b sen=%b hw=%0d",
                             e.id, $time, bus_if.queue_count, bus_if.car_in_queue, bus_if.queue_full,
                             bus_if.car_arrived, bus_if.farm_sensor, bus_if.head_wait,
                             e.cnt, e.ciq, e.full, e.arr, e.sen, e.hw);
                end
            end
        end
    end

    initial begin : stimulus
        int c;
        bus_if.arrival_Level_SWs = 5'd31;
        bus_if.add_Car           = 1'b0;

        // Reset held with heavy traffic: everything quiet.
        test_id = 8'd1;
        for (int i = 0; i < 4; i++) step(1'b1, 5'd31, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Comparator boundary against the seeded sequence 1, 0, 16, 24.
        test_id = 8'd11;
        step(1'b0, 5'd1,  1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 5'd0,  1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 5'd16, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 5'd25, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0);
        step(1'b1, 5'd31, 1'b0, 4'd1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 5'd31, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);

        // No arrivals at level 0.
        test_id = 8'd2;
        for (int i = 0; i < 64; i++) step(1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Departure requests on an empty queue are ignored.
        test_id = 8'd4;
        for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0, 8'd0);

        // Fill to capacity, sensor after 3 edges, head wait saturates at 255.
        test_id = 8'd3;
        for (int k = 0; k < 300; k++) begin
            c = (k < 15) ? k : 15;
            step(1'b0, 5'd31, 1'b0, 4'(c), (c != 15), (k >= 4),
                 8'((k < 1) ? 0 : ((k - 1 > 255) ? 255 : k - 1)));
        end

        // Drain one car per cycle; sensor drops one edge after empty.
        test_id = 8'd5;
        for (int j = 0; j < 18; j++) begin
            c = (j <= 15) ? 15 - j : 0;
            step(1'b0, 5'd0, 1'b1, 4'(c), 1'b0, (j <= 15), (j == 0) ? 8'd255 : 8'd0);
        end

        // Mixed arrivals and departures, including last-car swap.
        test_id = 8'd6;
        for (int i = 0; i < 19; i++)
            step(1'b0, t_lvl[i], t_add[i], t_cnt[i], t_arr[i], t_sen[i], t_hw[i]);

        // Reset in the middle of a request.
        test_id = 8'd7;
        step(1'b1, 5'd31, 1'b0, 4'd1, 1'b0, 1'b1, 8'd3);
        step(1'b1, 5'd31, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 5'd31, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge traffic_clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
